// File: rtl/scalar_ex_stage.sv
// Scalar execute stage: operand register X feeding an external ALU, result register R
// for writeback, and X/R forwarding into the operands of the op being accepted.
module scalar_ex_stage #(
  parameter int WIDTH = 36,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [REGW-1:0]  in_rs1,
  input  logic [REGW-1:0]  in_rs2,
  input  logic [REGW-1:0]  in_rd,
  input  logic             in_wen,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_nz,
  input  logic             alu_ez,
  input  logic             alu_lz,
  input  logic             alu_gz,
  input  logic             alu_le,
  input  logic             alu_ge,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [5:0]       out_flags,
  output logic [REGW-1:0]  out_rd,
  output logic             out_wen
);

  logic             x_v_q, x_v_d;
  logic [3:0]       x_op_q, x_op_d;
  logic [WIDTH-1:0] x_a_q, x_a_d;
  logic [WIDTH-1:0] x_b_q, x_b_d;
  logic [REGW-1:0]  x_rd_q, x_rd_d;
  logic             x_wen_q, x_wen_d;

  logic             r_v_q, r_v_d;
  logic [WIDTH-1:0] r_result_q, r_result_d;
  logic [5:0]       r_flags_q, r_flags_d;
  logic [REGW-1:0]  r_rd_q, r_rd_d;
  logic             r_wen_q, r_wen_d;

  logic             r_adv;
  logic             x_adv;
  logic             accept;
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;

  assign r_adv    = !r_v_q || out_ready;
  assign x_adv    = x_v_q && r_adv;
  assign in_ready = rst_n && (!x_v_q || r_adv);
  assign accept   = in_valid && in_ready;

  // The op in X beats the older op in R when both write the same register.
  always_comb begin
    fwd_a = in_a;
    if (x_v_q && x_wen_q && (x_rd_q == in_rs1) && (in_rs1 != '0)) begin
      fwd_a = alu_out;
    end else if (r_v_q && r_wen_q && (r_rd_q == in_rs1) && (in_rs1 != '0)) begin
      fwd_a = r_result_q;
    end
  end

  always_comb begin
    fwd_b = in_b;
    if (x_v_q && x_wen_q && (x_rd_q == in_rs2) && (in_rs2 != '0)) begin
      fwd_b = alu_out;
    end else if (r_v_q && r_wen_q && (r_rd_q == in_rs2) && (in_rs2 != '0)) begin
      fwd_b = r_result_q;
    end
  end

  always_comb begin
    x_v_d   = x_v_q;
    x_op_d  = x_op_q;
    x_a_d   = x_a_q;
    x_b_d   = x_b_q;
    x_rd_d  = x_rd_q;
    x_wen_d = x_wen_q;
    if (accept) begin
      x_v_d   = 1'b1;
      x_op_d  = in_op;
      x_a_d   = fwd_a;
      x_b_d   = fwd_b;
      x_rd_d  = in_rd;
      x_wen_d = in_wen;
    end else if (x_adv) begin
      x_v_d = 1'b0;
    end
  end

  always_comb begin
    r_v_d      = r_v_q;
    r_result_d = r_result_q;
    r_flags_d  = r_flags_q;
    r_rd_d     = r_rd_q;
    r_wen_d    = r_wen_q;
    if (x_adv) begin
      r_v_d      = 1'b1;
      r_result_d = alu_out;
      r_flags_d  = {alu_nz, alu_ez, alu_lz, alu_gz, alu_le, alu_ge};
      r_rd_d     = x_rd_q;
      r_wen_d    = x_wen_q;
    end else if (r_v_q && out_ready) begin
      r_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_v_q      <= 1'b0;
      x_op_q     <= '0;
      x_a_q      <= '0;
      x_b_q      <= '0;
      x_rd_q     <= '0;
      x_wen_q    <= 1'b0;
      r_v_q      <= 1'b0;
      r_result_q <= '0;
      r_flags_q  <= '0;
      r_rd_q     <= '0;
      r_wen_q    <= 1'b0;
    end else begin
      x_v_q      <= x_v_d;
      x_op_q     <= x_op_d;
      x_a_q      <= x_a_d;
      x_b_q      <= x_b_d;
      x_rd_q     <= x_rd_d;
      x_wen_q    <= x_wen_d;
      r_v_q      <= r_v_d;
      r_result_q <= r_result_d;
      r_flags_q  <= r_flags_d;
      r_rd_q     <= r_rd_d;
      r_wen_q    <= r_wen_d;
    end
  end

  assign alu_a      = x_a_q;
  assign alu_b      = x_b_q;
  assign alu_op     = x_op_q;
  assign out_valid  = r_v_q;
  assign out_result = r_result_q;
  assign out_flags  = r_flags_q;
  assign out_rd     = r_rd_q;
  assign out_wen    = r_wen_q;

endmodule
